// File: rtl/cpu_id_param.sv
// Parametrised PLP instruction-decode stage: regfile, control decode, load-use interlock, ID/EX register.
// Optional CPU_ID_BYPASS_EN: posedge regfile write with same-cycle WB bypass; otherwise negedge write.
module cpu_id_param #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_stall,
    input  logic            int_flush,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    input  logic            wb_rfw,
    input  logic [4:0]      wb_rf_waddr,
    input  logic [XLEN-1:0] wb_rf_wdata,
    output logic            c_stall,
    output logic            p_valid,
    output logic [XLEN-1:0] p_rfa,
    output logic [XLEN-1:0] p_rfb,
    output logic [XLEN-1:0] p_se,
    output logic [4:0]      p_shamt,
    output logic [5:0]      p_func,
    output logic [4:0]      p_rf_waddr,
    output logic            p_c_rfw,
    output logic [1:0]      p_c_wbsource,
    output logic [1:0]      p_c_drw,
    output logic [5:0]      p_c_alucontrol,
    output logic            p_c_j,
    output logic            p_c_b,
    output logic            p_c_jjr,
    output logic            p_c_rfbse,
    output logic [25:0]     p_jaddr,
    output logic [XLEN-1:0] p_pc,
    output logic [4:0]      p_rs,
    output logic [4:0]      p_rt
);
    localparam int AW = $clog2(NREG);
    localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [5:0] NREG_W = 6'(NREG);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_LAT - 1);

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign opcode = if_inst[31:26];
    assign rs     = if_inst[25:21];
    assign rt     = if_inst[20:16];
    assign rd     = if_inst[15:11];
    assign shamt  = if_inst[10:6];
    assign func   = if_inst[5:0];
    assign imm    = if_inst[15:0];

    // Index 0 and indices beyond the populated registers read as zero and drop writes.
    function automatic logic reg_ok(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < NREG_W);
    endfunction

    logic [XLEN-1:0] regs [0:(1<<AW)-1];
    logic            wr_en;
    logic [XLEN-1:0] rd_a;
    logic [XLEN-1:0] rd_b;

    assign wr_en = wb_rfw && !cpu_stall && reg_ok(wb_rf_waddr);

`ifdef CPU_ID_BYPASS_EN
    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[wb_rf_waddr[AW-1:0]] <= wb_rf_wdata;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (reg_ok(rs)) begin
            rd_a = (wb_rfw && wb_rf_waddr == rs) ? wb_rf_wdata : regs[rs[AW-1:0]];
        end
        if (reg_ok(rt)) begin
            rd_b = (wb_rfw && wb_rf_waddr == rt) ? wb_rf_wdata : regs[rt[AW-1:0]];
        end
    end
`else
    // Mid-cycle write lets the next posedge capture the freshly written value without a bypass mux.
    always_ff @(negedge clk) begin
        if (wr_en) begin
            regs[wb_rf_waddr[AW-1:0]] <= wb_rf_wdata;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (reg_ok(rs)) begin
            rd_a = regs[rs[AW-1:0]];
        end
        if (reg_ok(rt)) begin
            rd_b = regs[rt[AW-1:0]];
        end
    end
`endif

    logic            dec_rfw;
    logic [1:0]      dec_wbs;
    logic [1:0]      dec_drw;
    logic [XLEN-1:0] dec_se;
    logic            dec_rfbse;
    logic            dec_jjr;
    logic [4:0]      dec_waddr;
    logic            dec_j;
    logic            dec_b;

    always_comb begin
        dec_rfw   = !(opcode inside {6'h04, 6'h05, 6'h2b, 6'h02});
        dec_wbs   = 2'd0;
        dec_drw   = 2'b00;
        dec_se    = {{(XLEN-16){imm[15]}}, imm};
        dec_rfbse = !(opcode inside {6'h00, 6'h04, 6'h05});
        dec_jjr   = !(opcode inside {6'h02, 6'h03});
        dec_waddr = rt;
        dec_j     = 1'b0;
        dec_b     = opcode inside {6'h04, 6'h05};
        if (opcode == 6'h23) begin
            dec_wbs = 2'd1;
        end else if (opcode == 6'h03 || (opcode == 6'h00 && func == 6'h09)) begin
            dec_wbs = 2'd2;
        end
        if (opcode == 6'h2b) begin
            dec_drw = 2'b01;
        end else if (opcode == 6'h23) begin
            dec_drw = 2'b10;
        end
        if (opcode == 6'h0c || opcode == 6'h0d) begin
            dec_se = {{(XLEN-16){1'b0}}, imm};
        end
        if (opcode == 6'h00) begin
            dec_waddr = rd;
        end else if (opcode == 6'h03) begin
            dec_waddr = 5'd31;
        end
        if (opcode inside {6'h02, 6'h03} || (opcode == 6'h00 && func inside {6'h08, 6'h09})) begin
            dec_j = 1'b1;
        end
    end

    logic [CW-1:0] cnt;
    logic          detect;

    // A store of the loaded register needs no interlock; memory forwarding covers it.
    assign detect = p_valid && (p_c_drw == 2'b10) && (p_rt != 5'd0)
                    && (p_rt == rs || p_rt == rt) && (opcode != 6'h2b);
    assign c_stall = detect || (cnt != '0);

    always_ff @(posedge clk) begin
        if (!cpu_stall) begin
            if (rst || int_flush) begin
                cnt <= '0;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else if (detect) begin
                cnt <= CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!cpu_stall) begin
            if (rst || int_flush) begin
                p_valid        <= 1'b0;
                p_rfa          <= '0;
                p_rfb          <= '0;
                p_se           <= '0;
                p_shamt        <= '0;
                p_func         <= '0;
                p_rf_waddr     <= '0;
                p_c_rfw        <= 1'b0;
                p_c_wbsource   <= '0;
                p_c_drw        <= '0;
                p_c_alucontrol <= '0;
                p_c_j          <= 1'b0;
                p_c_b          <= 1'b0;
                p_c_jjr        <= 1'b0;
                p_c_rfbse      <= 1'b0;
                p_jaddr        <= '0;
                p_pc           <= '0;
                p_rs           <= '0;
                p_rt           <= '0;
            end else begin
                // A bubble keeps the decoded fields but strips every side effect.
                p_valid        <= !c_stall;
                p_rfa          <= rd_a;
                p_rfb          <= rd_b;
                p_se           <= dec_se;
                p_shamt        <= shamt;
                p_func         <= func;
                p_rf_waddr     <= dec_waddr;
                p_c_rfw        <= dec_rfw && !c_stall;
                p_c_wbsource   <= dec_wbs;
                p_c_drw        <= c_stall ? 2'b00 : dec_drw;
                p_c_alucontrol <= opcode;
                p_c_j          <= dec_j && !c_stall;
                p_c_b          <= dec_b && !c_stall;
                p_c_jjr        <= dec_jjr;
                p_c_rfbse      <= dec_rfbse;
                p_jaddr        <= if_inst[25:0];
                p_pc           <= if_pc;
                p_rs           <= rs;
                p_rt           <= rt;
            end
        end
    end
endmodule

// File: tb/tb_cpu_id_param.sv
// Scoreboard bench for cpu_id_param (NREG=16, LOAD_LAT=3): expectations queued at drive time, compared after the edge.
module tb_cpu_id_param;
    logic        clk;
    logic        rst;
    logic        cpu_stall;
    logic        int_flush;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        wb_rfw;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic        c_stall;
    logic        p_valid;
    logic [31:0] p_rfa;
    logic [31:0] p_rfb;
    logic [31:0] p_se;
    logic [4:0]  p_shamt;
    logic [5:0]  p_func;
    logic [4:0]  p_rf_waddr;
    logic        p_c_rfw;
    logic [1:0]  p_c_wbsource;
    logic [1:0]  p_c_drw;
    logic [5:0]  p_c_alucontrol;
    logic        p_c_j;
    logic        p_c_b;
    logic        p_c_jjr;
    logic        p_c_rfbse;
    logic [25:0] p_jaddr;
    logic [31:0] p_pc;
    logic [4:0]  p_rs;
    logic [4:0]  p_rt;

    cpu_id_param #(.XLEN(32), .NREG(16), .LOAD_LAT(3)) dut (
        .clk(clk), .rst(rst), .cpu_stall(cpu_stall), .int_flush(int_flush),
        .if_pc(if_pc), .if_inst(if_inst),
        .wb_rfw(wb_rfw), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
        .c_stall(c_stall), .p_valid(p_valid), .p_rfa(p_rfa), .p_rfb(p_rfb),
        .p_se(p_se), .p_shamt(p_shamt), .p_func(p_func), .p_rf_waddr(p_rf_waddr),
        .p_c_rfw(p_c_rfw), .p_c_wbsource(p_c_wbsource), .p_c_drw(p_c_drw),
        .p_c_alucontrol(p_c_alucontrol), .p_c_j(p_c_j), .p_c_b(p_c_b),
        .p_c_jjr(p_c_jjr), .p_c_rfbse(p_c_rfbse), .p_jaddr(p_jaddr),
        .p_pc(p_pc), .p_rs(p_rs), .p_rt(p_rt)
    );

    typedef struct {
        string       tag;
        logic        valid;
        logic [31:0] rfa, rfb, se, pc;
        logic [4:0]  waddr, shamt, rs, rt;
        logic        rfw, j, b, jjr, rfbse;
        logic [1:0]  wbs, drw;
        logic [5:0]  func, op;
        logic [25:0] jaddr;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    logic [31:0] ref_regs [0:15];
    logic [31:0] pc_ctr;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t zero_exp(input string tag);
        exp_t e;
        e.tag = tag; e.valid = 0; e.rfa = 0; e.rfb = 0; e.se = 0; e.pc = 0;
        e.waddr = 0; e.shamt = 0; e.rs = 0; e.rt = 0; e.rfw = 0; e.j = 0; e.b = 0;
        e.jjr = 0; e.rfbse = 0; e.wbs = 0; e.drw = 0; e.func = 0; e.op = 0; e.jaddr = 0;
        return e;
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] idx);
        if (idx == 0 || idx >= 16) return 32'h0;
        if (wb_rfw && wb_rf_waddr == idx) return wb_rf_wdata;
        return ref_regs[idx[3:0]];
    endfunction

    function automatic exp_t model(input logic [31:0] inst, input logic bub);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        op = inst[31:26];
        fn = inst[5:0];
        e = zero_exp("");
        e.valid = !bub; e.rs = inst[25:21]; e.rt = inst[20:16]; e.shamt = inst[10:6];
        e.func = fn; e.op = op; e.jaddr = inst[25:0]; e.pc = if_pc;
        e.rfa = opnd(inst[25:21]);
        e.rfb = opnd(inst[20:16]);
        e.se = (op == 6'h0c || op == 6'h0d) ? {16'h0, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};
        e.rfw = 1; e.rfbse = 1; e.jjr = 1; e.waddr = inst[20:16];
        case (op)
            6'h00: begin
                e.rfbse = 0; e.waddr = inst[15:11];
                if (fn == 6'h08) e.j = 1;
                if (fn == 6'h09) begin e.j = 1; e.wbs = 2; end
            end
            6'h02: begin e.rfw = 0; e.jjr = 0; e.j = 1; end
            6'h03: begin e.jjr = 0; e.j = 1; e.wbs = 2; e.waddr = 5'd31; end
            6'h04, 6'h05: begin e.rfw = 0; e.rfbse = 0; e.b = 1; end
            6'h23: begin e.wbs = 1; e.drw = 2'b10; end
            6'h2b: begin e.rfw = 0; e.drw = 2'b01; end
            default: ;
        endcase
        if (bub) begin e.rfw = 0; e.drw = 0; e.j = 0; e.b = 0; end
        return e;
    endfunction

    task automatic compare(input exp_t e);
        chk({e.tag, ".p_valid"}, p_valid, e.valid);
        chk({e.tag, ".p_rfa"}, p_rfa, e.rfa);
        chk({e.tag, ".p_rfb"}, p_rfb, e.rfb);
        chk({e.tag, ".p_se"}, p_se, e.se);
        chk({e.tag, ".p_shamt"}, p_shamt, e.shamt);
        chk({e.tag, ".p_func"}, p_func, e.func);
        chk({e.tag, ".p_rf_waddr"}, p_rf_waddr, e.waddr);
        chk({e.tag, ".p_c_rfw"}, p_c_rfw, e.rfw);
        chk({e.tag, ".p_c_wbsource"}, p_c_wbsource, e.wbs);
        chk({e.tag, ".p_c_drw"}, p_c_drw, e.drw);
        chk({e.tag, ".p_c_alucontrol"}, p_c_alucontrol, e.op);
        chk({e.tag, ".p_c_j"}, p_c_j, e.j);
        chk({e.tag, ".p_c_b"}, p_c_b, e.b);
        chk({e.tag, ".p_c_jjr"}, p_c_jjr, e.jjr);
        chk({e.tag, ".p_c_rfbse"}, p_c_rfbse, e.rfbse);
        chk({e.tag, ".p_jaddr"}, p_jaddr, e.jaddr);
        chk({e.tag, ".p_pc"}, p_pc, e.pc);
        chk({e.tag, ".p_rs"}, p_rs, e.rs);
        chk({e.tag, ".p_rt"}, p_rt, e.rt);
    endtask

    // Called at posedge+1; drives one ID cycle and checks the resulting ID/EX contents.
    task automatic step(input string tag, input logic [31:0] inst, input logic wbe,
                        input logic [4:0] wa, input logic [31:0] wd, input logic exp_stall,
                        input logic flush, input logic freeze, input logic rst_v);
        exp_t e;
        if_inst = inst; if_pc = pc_ctr; pc_ctr = pc_ctr + 4;
        wb_rfw = wbe; wb_rf_waddr = wa; wb_rf_wdata = wd;
        int_flush = flush; cpu_stall = freeze; rst = rst_v;
        #2;
        chk({tag, ".c_stall"}, c_stall, exp_stall);
        if (freeze) e = last_exp;
        else if (flush || rst_v) e = zero_exp("");
        else e = model(inst, exp_stall);
        e.tag = tag;
        sb.push_back(e);
        if (wbe && !freeze && wa != 0 && wa < 16) ref_regs[wa[3:0]] = wd;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(e);
        last_exp = e;
    endtask

    initial begin
        checks = 0; failures = 0; pc_ctr = 32'h0000_0400;
        for (int i = 0; i < 16; i++) ref_regs[i] = 32'h0;
        rst = 1; cpu_stall = 0; int_flush = 0; if_pc = 0; if_inst = 0;
        wb_rfw = 0; wb_rf_waddr = 0; wb_rf_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        last_exp = zero_exp("reset");
        compare(last_exp);
        chk("reset.c_stall", c_stall, 1'b0);

        step("init_r1", 32'h0000_0000, 1, 5'd1, 32'h0000_1000, 0, 0, 0, 0);
        step("init_r2", 32'h0000_0000, 1, 5'd2, 32'h0000_0022, 0, 0, 0, 0);
        step("init_r4", 32'h0000_0000, 1, 5'd4, 32'h0000_0044, 0, 0, 0, 0);
        step("init_r9", 32'h0000_0000, 1, 5'd9, 32'h0000_0099, 0, 0, 0, 0);
        step("bypass_r5", 32'h00A0_1821, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        step("read_r5", 32'h00A5_3021, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        step("nreg_r20", 32'h0280_1821, 1, 5'd20, 32'h0000_0055, 0, 0, 0, 0);
        step("ori_zext", 32'h3407_8001, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        step("addiu_sext", 32'h2407_8001, 0, 5'd0, 32'h0, 0, 0, 0, 0);

        step("lw", 32'h8C24_0000, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        step("bub1", 32'h0084_1021, 0, 5'd0, 32'h0, 1, 0, 0, 0);
        step("bub2_wb", 32'h0084_1021, 1, 5'd8, 32'h0000_0088, 1, 0, 0, 0);
        step("bub3", 32'h0084_1021, 0, 5'd0, 32'h0, 1, 0, 0, 0);
        step("add_issue", 32'h0084_1021, 0, 5'd0, 32'h0, 0, 0, 0, 0);

        step("lw_sw", 32'h8C24_0000, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        step("sw_nostall", 32'hAC24_0004, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        step("jal", 32'h0C00_0010, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        step("beq", 32'h1022_0003, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        step("jr", 32'h03E0_0008, 0, 5'd0, 32'h0, 0, 0, 0, 0);

        step("fl_lw", 32'h8C24_0000, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        step("fl_bub1", 32'h0084_1021, 0, 5'd0, 32'h0, 1, 0, 0, 0);
        step("fl_flush", 32'h0084_1021, 0, 5'd0, 32'h0, 1, 1, 0, 0);
        step("fl_issue", 32'h0084_1021, 0, 5'd0, 32'h0, 0, 0, 0, 0);

        for (int k = 0; k < 4; k++) begin
            step($sformatf("freeze%0d", k), 32'h3407_8001, 1, 5'd9, 32'h0000_1234,
                 0, (k == 2), 1, (k == 1));
        end
        step("after_freeze", 32'h0109_5021, 0, 5'd0, 32'h0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_id_param.md
Name: cpu_id_param

Overview:
Parametrised instruction-decode stage for the PLP pipeline. It sits between fetch and execute and contains the register file, control decode and the ID/EX pipeline register. Compared with the fixed 32x32 decode stage, it adds configurable datapath width and register count, a same-cycle writeback bypass, a load-use interlock with configurable length, and a valid bit on the pipeline register.

Parameters:
XLEN, 32, datapath width (>=32; immediates and PC are extended to XLEN)
NREG, 32, number of architectural registers (8..32; reg 0 hardwired to zero)
LOAD_LAT, 1, number of bubble cycles inserted on a load-use hazard (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_stall  in  1  global freeze: holds all state, including regfile writes and the stall counter
int_flush  in  1  interrupt flush: the pipeline register takes its reset values
if_pc  in  XLEN  PC of the fetched instruction
if_inst  in  32  fetched instruction
wb_rfw  in  1  writeback write enable
wb_rf_waddr  in  5  writeback address
wb_rf_wdata  in  XLEN  writeback data
c_stall  out  1  hazard stall request to fetch (combinational)
p_valid  out  1  EX-stage instruction valid (0 = bubble)
p_rfa, p_rfb  out  XLEN  rs/rt operands
p_se  out  XLEN  sign- or zero-extended immediate
p_shamt  out  5  shift amount
p_func  out  6  function field
p_rf_waddr  out  5  destination register
p_c_rfw  out  1  register write enable
p_c_wbsource  out  2  writeback source: 0 ALU, 1 memory, 2 link
p_c_drw  out  2  data memory access: 01 write, 10 read, 00 none
p_c_alucontrol  out  6  opcode
p_c_j, p_c_b, p_c_jjr, p_c_rfbse  out  1  jump, branch, jump-register select, rfb-vs-immediate select
p_jaddr  out  26  jump target field
p_pc  out  XLEN  PC passed to EX
p_rs, p_rt  out  5  source register indices for forwarding

Behaviour:
- Clocking and reset:
  - Reset rst is synchronous and active-high; the clock is clk. All state updates on the posedge of clk.
  - rst or int_flush (when cpu_stall=0): every p_* output goes to 0, including p_valid; the stall counter goes to 0. The regfile is not cleared.
  - rst has priority over the stall counter. When cpu_stall=1, nothing changes, including on rst or int_flush.
- Regfile:
  - NREG x XLEN storage.
  - Reads of index 0, or of any index >= NREG, return 0. Writes to those indices are ignored.
  - Writes occur on the posedge when wb_rfw=1 and cpu_stall=0.
- Bypass:
  - If wb_rfw=1 and wb_rf_waddr equals rs or rt (nonzero and < NREG), the read returns wb_rf_wdata in the same cycle.
- Decode:
  - rfw: 0 for opcodes 04, 05, 2b, 02; otherwise 1.
  - wbsource: 1 for 23; 2 for 03 and for opcode 00 with func 09; otherwise 0.
  - drw: 01 for 2b, 10 for 23, otherwise 00.
  - Immediate extension: zero-extend for 0c and 0d; sign-extend otherwise.
  - rfbse: 0 for opcodes 00, 04, 05; otherwise 1.
  - jjr: 0 for 02 and 03; otherwise 1.
  - Destination: rd for opcode 00, register 31 for 03, rt otherwise.
  - j: opcodes 02 and 03, and opcode 00 with func 08 or 09.
  - b: opcodes 04 and 05.
- Hazard detection:
  - detect = p_valid & p_c_drw==10 & p_rt!=0 & (p_rt==rs | p_rt==rt) & opcode!=2b.
  - c_stall = detect | (cnt!=0).
  - On detect with cnt==0: cnt <= LOAD_LAT-1.
  - While cnt!=0 and cpu_stall=0: cnt decrements.
  - The counter width is sized for LOAD_LAT-1.
- Bubble (when c_stall=1):
  - Pipeline register loads with p_valid=0, rfw=0, drw=00, j=0, b=0.
  - Other fields load normally.
  - Fetch holds if_inst, so the instruction re-decodes when c_stall drops.
- Normal operation: p_valid=1 and all fields load. Latency from ID to EX is 1 cycle.
- Simultaneous events:
  - int_flush during a stall: the flush wins and cnt clears.
  - Writeback during a stall: the write still occurs.

Optional Feature:
CPU_ID_BYPASS_EN.
- Defined: same-cycle WB-to-ID bypass as above; regfile writes on the posedge.
- Undefined: no bypass mux. The regfile writes on the negedge of clk (gated by cpu_stall), so a read in the following half-cycle sees the new value.
- Architecturally visible results are identical; only timing and area differ.

Test Plan:
- rst=1 for 2 cycles -> every p_* output 0, p_valid=0, c_stall=0.
- WB writes r5=0xDEADBEEF while if_inst = addu r3,r5,r0 (00A01821) -> next cycle p_rfa=0xDEADBEEF, p_rf_waddr=3, p_c_rfw=1, p_valid=1.
- LOAD_LAT=1: lw r4,0(r1) followed by addu r2,r4,r4 -> exactly 1 bubble cycle with c_stall=1, p_valid=0, p_c_rfw=0; then the add issues.
- LOAD_LAT=3: same sequence -> c_stall high for 3 consecutive cycles; sw r4 after lw r4 -> no stall.
- NREG=16: write r20=0x55, read r20 -> 0; ori r7,r0,0x8001 -> p_se=0x00008001; addiu with 0x8001 -> p_se=0xFFFF8001.
- int_flush asserted during the 2nd cycle of a LOAD_LAT=3 stall -> pipeline register zeroed, cnt=0, c_stall drops next cycle; cpu_stall=1 for 4 cycles -> all outputs and regfile unchanged.
